calculator: RTL and testbench
=============================

Name: calculator

Overview:
- Self-contained 8-bit accumulator calculator. It has no data inputs.
- On reset it executes a fixed program held in an internal ROM, one instruction per clock.
- It drives the value written by each OUT instruction onto `result`.
- It serves as a standalone top-level demo block; its only stimulus is clock and reset.

Parameters:
- DATA_W, 8, width of accumulator, registers and `result`.
- PROG_DEPTH, 16, number of ROM instruction words.
- PC_W, 4, program counter width, equal to log2(PROG_DEPTH).

Ports:
- clk  input  1  rising-edge clock; sole clock domain.
- reset  input  1  synchronous, active-high reset.
- result  output  8  registered output; holds the last value written by an OUT instruction.

Behaviour:
- Instruction word is 12 bits: op[11:8], imm[7:0]. Register-addressed ops use imm[1:0] to select R0..R3.
- State: pc (4b), acc (8b), R0..R3 (8b each), run state (RUN/HALTED), result register.
- Reset, sampled on a rising edge: pc=0, acc=0, R0..R3=0, state=RUN, result=0x00. Reset has priority over any instruction executing in that cycle.
- RUN: each rising edge executes ROM[pc] and then pc = pc+1, which wraps from 15 to 0.
- HALTED: pc, acc, registers and result are frozen. Only reset leaves HALTED.
- All arithmetic is modulo 256; no flags are kept.
- Opcodes:
  - 0 NOP.
  - 1 LDI: acc=imm.
  - 2 ADDI: acc+=imm.
  - 3 SUBI: acc-=imm.
  - 4 ADD: acc+=Rn.
  - 5 SUB: acc-=Rn.
  - 6 MUL: acc = low 8 bits of acc*Rn.
  - 7 AND, 8 OR, 9 XOR: acc op= Rn.
  - A SHL: acc <<= imm[2:0], zero fill.
  - B SHR: acc >>= imm[2:0], logical.
  - C STR: Rn=acc.
  - D LDR: acc=Rn.
  - E OUT: result=acc.
  - F HALT: state=HALTED, pc not incremented.
- Latency: an OUT at ROM address k updates `result` on the (k+1)-th rising edge after the reset edge. The new value is visible immediately after that edge.
- `result` changes only on OUT or reset.
- Fixed ROM program (address: instruction → acc after it):
  - 0: LDI 0x05 → 0x05.
  - 1: STR R0.
  - 2: ADDI 0x03 → 0x08.
  - 3: OUT → result=0x08.
  - 4: MUL R0 → 0x28.
  - 5: OUT → result=0x28.
  - 6: SUBI 0x02 → 0x26.
  - 7: SHL 1 → 0x4C.
  - 8: OUT → result=0x4C.
  - 9: XOR R0 → 0x49.
  - 10: OUT → result=0x49.
  - 11: HALT.
  - 12–15: NOP.

Decomposition:
- Package calculator_pkg holds:
  - DATA_W, PC_W and PROG_DEPTH constants.
  - An opcode enum of 4 bits.
  - The instruction struct {op, imm}.
- One sub-module, calculator_rom: combinational lookup from a 4-bit address to a 12-bit instruction containing the fixed program.
- The core (decode, ALU, register file, FSM) remains in calculator.

Test Plan:
- Hold reset high across 2 edges → result=0x00, pc=0; result stays 0x00 through edge 3 after release.
- Release reset → result=0x08 after edge 4, 0x28 after edge 6, 0x4C after edge 9, 0x49 after edge 11.
- Run 50 further edges after HALT → result remains 0x49 and pc remains 11.
- Assert reset for 1 edge mid-program (after edge 7) → result=0x00 at once; the sequence restarts and reaches 0x08 four edges after release.
- Pulse reset between clock edges without covering a rising edge → no state change, confirming reset is synchronous.
- Arithmetic wrap, using an alternate ROM image: LDI 0xFF, ADDI 0x02, OUT → result=0x01. Also LDI 0x00, SUBI 0x01, OUT → result=0xFF.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared constants, opcode encoding and instruction layout for the accumulator calculator.
package calculator_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PROG_DEPTH = 16;
  localparam int unsigned PC_W       = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADDI = 4'h2,
    OP_SUBI = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_MUL  = 4'h6,
    OP_AND  = 4'h7,
    OP_OR   = 4'h8,
    OP_XOR  = 4'h9,
    OP_SHL  = 4'hA,
    OP_SHR  = 4'hB,
    OP_STR  = 4'hC,
    OP_LDR  = 4'hD,
    OP_OUT  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef struct packed {
    opcode_e     op;
    logic [7:0]  imm;
  } instr_t;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_e;

  function automatic instr_t mk_instr(opcode_e op, logic [7:0] imm);
    instr_t w;
    w.op  = op;
    w.imm = imm;
    return w;
  endfunction

endpackage

// File: rtl/calculator_rom.sv
// Combinational program ROM; ROM_SEL=0 is the demo program, ROM_SEL=1 an arithmetic-wrap image.
module calculator_rom
  import calculator_pkg::*;
#(
  parameter int unsigned ROM_SEL = 0
) (
  input  logic [PC_W-1:0] addr_i,
  output instr_t          instr_o
);

  always_comb begin
    instr_o = mk_instr(OP_NOP, '0);
    if (ROM_SEL == 0) begin
      case (addr_i)
        4'd0:  instr_o = mk_instr(OP_LDI,  8'h05);
        4'd1:  instr_o = mk_instr(OP_STR,  8'h00);
        4'd2:  instr_o = mk_instr(OP_ADDI, 8'h03);
        4'd3:  instr_o = mk_instr(OP_OUT,  8'h00);
        4'd4:  instr_o = mk_instr(OP_MUL,  8'h00);
        4'd5:  instr_o = mk_instr(OP_OUT,  8'h00);
        4'd6:  instr_o = mk_instr(OP_SUBI, 8'h02);
        4'd7:  instr_o = mk_instr(OP_SHL,  8'h01);
        4'd8:  instr_o = mk_instr(OP_OUT,  8'h00);
        4'd9:  instr_o = mk_instr(OP_XOR,  8'h00);
        4'd10: instr_o = mk_instr(OP_OUT,  8'h00);
        4'd11: instr_o = mk_instr(OP_HALT, 8'h00);
        default: instr_o = mk_instr(OP_NOP, '0);
      endcase
    end else begin
      case (addr_i)
        4'd0:  instr_o = mk_instr(OP_LDI,  8'hFF);
        4'd1:  instr_o = mk_instr(OP_ADDI, 8'h02);
        4'd2:  instr_o = mk_instr(OP_OUT,  8'h00);
        4'd3:  instr_o = mk_instr(OP_LDI,  8'h00);
        4'd4:  instr_o = mk_instr(OP_SUBI, 8'h01);
        4'd5:  instr_o = mk_instr(OP_OUT,  8'h00);
        4'd6:  instr_o = mk_instr(OP_HALT, 8'h00);
        default: instr_o = mk_instr(OP_NOP, '0);
      endcase
    end
  end

endmodule

// File: rtl/calculator.sv
// 8-bit accumulator machine running a fixed ROM program; OUT instructions update `result`.
module calculator
  import calculator_pkg::*;
#(
  parameter int unsigned ROM_SEL = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] result
);

  state_e                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [DATA_W-1:0]      acc_q, acc_d;
  logic [DATA_W-1:0]      result_q, result_d;
  logic [3:0][DATA_W-1:0] regs_q, regs_d;
  instr_t                 instr;
  logic                   exec_en;
  logic [DATA_W-1:0]      rn;
  logic [DATA_W-1:0]      prod;

  calculator_rom #(.ROM_SEL(ROM_SEL)) u_rom (
    .addr_i  (pc_q),
    .instr_o (instr)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && instr.op == OP_HALT) state_d = ST_HALTED;
  end

  always_comb begin
    exec_en = (state_q == ST_RUN);
  end

  // Product evaluated in DATA_W context keeps only the low byte, i.e. modulo 256.
  always_comb begin
    rn       = regs_q[instr.imm[1:0]];
    prod     = acc_q * rn;
    acc_d    = acc_q;
    regs_d   = regs_q;
    result_d = result_q;
    pc_d     = pc_q;
    if (exec_en) begin
      if (instr.op != OP_HALT) pc_d = pc_q + PC_W'(1);
      unique case (instr.op)
        OP_NOP:  ;
        OP_LDI:  acc_d = instr.imm;
        OP_ADDI: acc_d = acc_q + instr.imm;
        OP_SUBI: acc_d = acc_q - instr.imm;
        OP_ADD:  acc_d = acc_q + rn;
        OP_SUB:  acc_d = acc_q - rn;
        OP_MUL:  acc_d = prod;
        OP_AND:  acc_d = acc_q & rn;
        OP_OR:   acc_d = acc_q | rn;
        OP_XOR:  acc_d = acc_q ^ rn;
        OP_SHL:  acc_d = acc_q << instr.imm[2:0];
        OP_SHR:  acc_d = acc_q >> instr.imm[2:0];
        OP_STR:  regs_d[instr.imm[1:0]] = acc_q;
        OP_LDR:  acc_d = rn;
        OP_OUT:  result_d = acc_q;
        OP_HALT: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      acc_q    <= '0;
      regs_q   <= '0;
      result_q <= '0;
    end else begin
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      regs_q   <= regs_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_calculator.sv
// Bench for calculator: ISA-level interpreter model checked every cycle, plus literal program milestones.
module tb_calculator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] result;
  logic [7:0] result_alt;

  int checks = 0;
  int failures = 0;

  calculator dut (
    .clk    (clk),
    .reset  (reset),
    .result (result)
  );

  calculator #(.ROM_SEL(1)) dut_alt (
    .clk    (clk),
    .reset  (reset),
    .result (result_alt)
  );

  always #5 clk = ~clk;

  logic [11:0] rom_main [16] = '{12'h105, 12'hC00, 12'h203, 12'hE00, 12'h600, 12'hE00,
                                 12'h302, 12'hA01, 12'hE00, 12'h900, 12'hE00, 12'hF00,
                                 12'h000, 12'h000, 12'h000, 12'h000};
  logic [11:0] rom_alt  [16] = '{12'h1FF, 12'h202, 12'hE00, 12'h100, 12'h301, 12'hE00,
                                 12'hF00, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
                                 12'h000, 12'h000, 12'h000, 12'h000};

  typedef struct {
    int pc;
    int acc;
    int r[4];
    bit halted;
    int result;
  } mstate_t;

  mstate_t m_main, m_alt;
  bit      mvalid = 1'b0;

  function automatic mstate_t reset_state();
    mstate_t s;
    s.pc = 0; s.acc = 0; s.halted = 1'b0; s.result = 0;
    for (int i = 0; i < 4; i++) s.r[i] = 0;
    return s;
  endfunction

  function automatic mstate_t step(mstate_t s, bit alt);
    logic [11:0] w;
    int op, imm, rn;
    if (s.halted) return s;
    w   = alt ? rom_alt[s.pc] : rom_main[s.pc];
    op  = int'(w[11:8]);
    imm = int'(w[7:0]);
    rn  = s.r[imm % 4];
    case (op)
      1:  s.acc = imm;
      2:  s.acc = (s.acc + imm) % 256;
      3:  s.acc = (s.acc - imm + 256) % 256;
      4:  s.acc = (s.acc + rn) % 256;
      5:  s.acc = (s.acc - rn + 256) % 256;
      6:  s.acc = (s.acc * rn) % 256;
      7:  s.acc = s.acc & rn;
      8:  s.acc = s.acc | rn;
      9:  s.acc = s.acc ^ rn;
      10: s.acc = (s.acc * (1 << (imm % 8))) % 256;
      11: s.acc = s.acc / (1 << (imm % 8));
      12: s.r[imm % 4] = s.acc;
      13: s.acc = rn;
      14: s.result = s.acc;
      default: ;
    endcase
    if (op == 15) s.halted = 1'b1;
    else          s.pc = (s.pc + 1) % 16;
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_main <= reset_state();
      m_alt  <= reset_state();
      mvalid <= 1'b1;
    end else if (mvalid) begin
      m_main <= step(m_main, 1'b0);
      m_alt  <= step(m_alt, 1'b1);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      check("cyc_result", int'(result), m_main.result);
      check("cyc_pc", int'(dut.pc_q), m_main.pc);
      check("cyc_alt_result", int'(result_alt), m_alt.result);
    end
  end

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, n;
    reset = 1'b1;
    repeat (2) edge_sample();
    check("rst_result", int'(result), 8'h00);
    check("rst_pc", int'(dut.pc_q), 0);
    check("rst_model", m_main.result, 0);
    @(negedge clk) reset = 1'b0;

    for (int e = 1; e <= 11; e++) begin
      edge_sample();
      case (e)
        3:  begin
              check("e3_result", int'(result), 8'h00);
              check("alt_wrap_add", int'(result_alt), 8'h01);
            end
        4:  begin
              check("e4_result", int'(result), 8'h08);
              check("e4_model", m_main.result, 8'h08);
            end
        6:  begin
              check("e6_result", int'(result), 8'h28);
              check("alt_wrap_sub", int'(result_alt), 8'hFF);
            end
        9:  check("e9_result", int'(result), 8'h4C);
        11: begin
              check("e11_result", int'(result), 8'h49);
              check("e11_model", m_main.result, 8'h49);
            end
        default: ;
      endcase
    end

    repeat (50) edge_sample();
    check("halt_result", int'(result), 8'h49);
    check("halt_pc", int'(dut.pc_q), 11);
    check("halt_model_pc", m_main.pc, 11);

    // Restart, then reset for one edge after edge 7.
    @(negedge clk) reset = 1'b1;
    edge_sample();
    @(negedge clk) reset = 1'b0;
    repeat (7) edge_sample();
    check("mid_pre_result", int'(result), 8'h28);
    @(negedge clk) reset = 1'b1;
    edge_sample();
    check("mid_rst_result", int'(result), 8'h00);
    check("mid_rst_pc", int'(dut.pc_q), 0);
    @(negedge clk) reset = 1'b0;
    repeat (3) edge_sample();
    check("mid_e3_result", int'(result), 8'h00);
    edge_sample();
    check("mid_e4_result", int'(result), 8'h08);

    // Reset pulse that covers no rising edge must be ignored.
    @(negedge clk);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    edge_sample();
    check("glitch_pc", int'(dut.pc_q), 5);
    check("glitch_result", int'(result), 8'h08);
    edge_sample();
    check("glitch_e6_result", int'(result), 8'h28);

    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 2));
      case (sel)
        0: begin
             n = int'($urandom_range(1, 20));
             repeat (n) edge_sample();
           end
        1: begin
             n = int'($urandom_range(1, 3));
             @(negedge clk) reset = 1'b1;
             repeat (n) edge_sample();
             @(negedge clk) reset = 1'b0;
           end
        default: begin
             @(negedge clk);
             #($urandom_range(1, 3)) reset = 1'b1;
             #1 reset = 1'b0;
             edge_sample();
           end
      endcase
    end
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
